// File: rtl/seq_pkg.sv
// Shared types and helpers for the multi-track sequencer core.
package seq_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int MIX_GUARD = 3;

  // 16th-note step: accumulator threshold giving a period of LIMIT/bpm cycles.
  function automatic logic [31:0] step_limit(input longint clk_hz);
    return 32'(15 * clk_hz);
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/seq_square_voice.sv
// One square-wave voice: half-period counter and phase bit.
// A new half-period is only picked up at a counter wrap, so edits never glitch a half-cycle.
module seq_square_voice #(
  parameter int HP_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [HP_W-1:0] i_half_period,
  output logic            o_phase
);

  logic [HP_W-1:0] r_cnt;
  logic [HP_W-1:0] r_hp;
  logic            r_phase;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_hp    <= '0;
      r_phase <= 1'b0;
    end else if (r_hp == '0) begin
      r_cnt <= '0;
      r_hp  <= i_half_period;
    end else if (r_cnt >= r_hp - HP_W'(1)) begin
      r_cnt   <= '0;
      r_hp    <= i_half_period;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + HP_W'(1);
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/seq_multitrack_engine.sv
// Multi-track step-sequencer playback: BPM step timer, loop counting, saturating voice mix, valid/ready output.
// Optional macro ACCENT_EN adds an accent input doubling the amplitude of accented hits.
//   state  | meaning
//   S_IDLE | stopped, mix forced to 0, waiting for start
//   S_RUN  | stepping through the pattern, voices audible
module seq_multitrack_engine
  import seq_pkg::*;
#(
  parameter int                  NUM_TRACKS = 4,
  parameter int                  NUM_STEPS  = 16,
  parameter int                  SAMPLE_W   = 32,
  parameter logic [SAMPLE_W-1:0] AMPLITUDE  = SAMPLE_W'(32'h0800_0000),
  parameter int                  CLK_HZ     = 50_000_000,
  parameter int                  BPM_W      = 10,
  parameter int                  LOOP_W     = 7,
  parameter int                  HP_W       = 16,
  localparam int                 SI_W       = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stop,
  input  logic [BPM_W-1:0]               bpm,
  input  logic [LOOP_W-1:0]              loops,
  input  logic [NUM_TRACKS*NUM_STEPS-1:0] pattern,
`ifdef ACCENT_EN
  input  logic [NUM_TRACKS*NUM_STEPS-1:0] accent,
`endif
  input  logic [NUM_TRACKS*HP_W-1:0]     half_period,
  output logic signed [SAMPLE_W-1:0]     sample,
  output logic                           sample_valid,
  input  logic                           sample_ready,
  output logic [SI_W-1:0]                step_idx,
  output logic                           step_pulse,
  output logic                           playing,
  output logic                           done
);

  localparam logic [31:0] LIMIT = step_limit(CLK_HZ);
  localparam int          SUM_W = SAMPLE_W + MIX_GUARD;

  state_t                     r_state;
  logic [31:0]                r_acc;
  logic [LOOP_W-1:0]          r_loop;
  logic [SI_W-1:0]            r_step;
  logic                       r_pulse;
  logic                       r_done;
  logic                       r_valid;
  logic signed [SAMPLE_W-1:0] r_mix;
  logic signed [SAMPLE_W-1:0] r_sample;

  logic [NUM_TRACKS-1:0]      w_phase;
  logic [32:0]                w_acc_sum;
  logic                       w_fire;
  logic                       w_wrap;
  logic [LOOP_W-1:0]          w_loop_inc;
  logic signed [SUM_W-1:0]    w_sum;
  logic signed [SUM_W-1:0]    w_amp;
  logic [NUM_STEPS-1:0]       w_tpat;
`ifdef ACCENT_EN
  logic [NUM_STEPS-1:0]       w_tacc;
`endif
  logic signed [SAMPLE_W-1:0] w_mix;

  for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_voice
    seq_square_voice #(.HP_W(HP_W)) u_voice (
      .i_clk        (CLOCK_50),
      .i_rst        (reset),
      .i_half_period(half_period[t*HP_W +: HP_W]),
      .o_phase      (w_phase[t])
    );
  end

  assign w_acc_sum  = {1'b0, r_acc} + 33'(bpm);
  assign w_fire     = (w_acc_sum >= {1'b0, LIMIT});
  assign w_wrap     = (r_step == SI_W'(NUM_STEPS - 1));
  assign w_loop_inc = r_loop + LOOP_W'(1);

  // Guard bits keep the raw sum exact; clipping happens once at the end.
  always_comb begin
    w_sum  = '0;
    w_amp  = '0;
    w_tpat = '0;
`ifdef ACCENT_EN
    w_tacc = '0;
`endif
    for (int t = 0; t < NUM_TRACKS; t++) begin
      w_tpat = pattern[t*NUM_STEPS +: NUM_STEPS];
      w_amp  = SUM_W'(AMPLITUDE);
`ifdef ACCENT_EN
      w_tacc = accent[t*NUM_STEPS +: NUM_STEPS];
      if (w_tacc[r_step]) w_amp = w_amp <<< 1;
`endif
      if (r_state == S_RUN && w_tpat[r_step] && half_period[t*HP_W +: HP_W] != '0) begin
        w_sum = w_phase[t] ? (w_sum + w_amp) : (w_sum - w_amp);
      end
    end
    w_mix = SAMPLE_W'(sat_add(64'(w_sum), 64'sd0, SAMPLE_W));
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_loop   <= '0;
      r_step   <= '0;
      r_pulse  <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_mix    <= '0;
      r_sample <= '0;
    end else begin
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b1;
      r_mix   <= w_mix;
      if (r_valid && sample_ready) r_sample <= r_mix;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state <= S_RUN;
            r_acc   <= '0;
            r_loop  <= '0;
            r_step  <= '0;
          end
        end
        S_RUN: begin
          if (stop || start) begin
            r_state <= stop ? S_IDLE : S_RUN;
            r_acc   <= '0;
            r_loop  <= '0;
            r_step  <= '0;
          end else if (w_fire) begin
            r_acc   <= 32'(w_acc_sum - {1'b0, LIMIT});
            r_pulse <= 1'b1;
            if (w_wrap) begin
              r_step <= '0;
              r_loop <= w_loop_inc;
              if (loops != '0 && w_loop_inc == loops) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
                r_loop  <= '0;
              end
            end else begin
              r_step <= r_step + SI_W'(1);
            end
          end else begin
            r_acc <= w_acc_sum[31:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign step_idx     = r_step;
  assign step_pulse   = r_pulse;
  assign playing      = (r_state == S_RUN);
  assign done         = r_done;

endmodule

// File: tb/tb_seq_multitrack_engine.sv
// Directed bench for seq_multitrack_engine with a 1 kHz clock model, 4 tracks, 4 steps.
module tb_seq_multitrack_engine;

  localparam logic signed [31:0] AP   = 32'sh3000_0000;
  localparam logic signed [31:0] AN   = -32'sh3000_0000;
  localparam logic signed [31:0] SMAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SMIN = 32'sh8000_0000;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic [9:0]         bpm;
  logic [6:0]         loops;
  logic [15:0]        pattern;
`ifdef ACCENT_EN
  logic [15:0]        accent;
`endif
  logic [63:0]        half_period;
  logic signed [31:0] sample;
  logic               sample_valid;
  logic               sample_ready;
  logic [1:0]         step_idx;
  logic               step_pulse;
  logic               playing;
  logic               done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  logic signed [31:0] v0 = '0;

  seq_multitrack_engine #(
    .NUM_TRACKS(4), .NUM_STEPS(4), .SAMPLE_W(32), .AMPLITUDE(32'h3000_0000),
    .CLK_HZ(1000), .BPM_W(10), .LOOP_W(7), .HP_W(16)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .start       (start),
    .stop        (stop),
    .bpm         (bpm),
    .loops       (loops),
    .pattern     (pattern),
`ifdef ACCENT_EN
    .accent      (accent),
`endif
    .half_period (half_period),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .step_idx    (step_idx),
    .step_pulse  (step_pulse),
    .playing     (playing),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Track-0 tone reference: sample flips every 5 cycles starting from the transition seen at c0.
  function automatic logic signed [31:0] exp_tone(input int c);
    if (((c - c0) / 5) % 2 == 0) return v0;
    return -v0;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++; if (sample !== 32'sd0) begin errors++; $display("FAIL %s sample: got %h expected 0", tag, sample); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL %s sample_valid: got %b expected 0", tag, sample_valid); end
    checks++; if (step_idx !== 2'd0) begin errors++; $display("FAIL %s step_idx: got %0d expected 0", tag, step_idx); end
    checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL %s step_pulse: got %b expected 0", tag, step_pulse); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL %s playing: got %b expected 0", tag, playing); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done: got %b expected 0", tag, done); end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL valid_after_reset: got %b expected 1", sample_valid); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 0", playing); end
  endtask

  task automatic test_step_timer();
    int n;
    logic [1:0] exp_idx;
    bpm = 10'd60; loops = 7'd2; pattern = 16'h0000;
    pulse_start();
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL timer_entry_playing: got %b expected 1", playing); end
    checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL timer_entry_pulse: got %b expected 0", step_pulse); end
    checks++; if (step_idx !== 2'd0) begin errors++; $display("FAIL timer_entry_idx: got %0d expected 0", step_idx); end
    n = 0;
    for (int c = 1; c <= 2100; c++) begin
      tick();
      if (step_pulse) begin
        n++;
        exp_idx = 2'(n % 4);
        checks++; if (c != 250 * n) begin errors++; $display("FAIL timer_period: pulse %0d at cycle %0d expected %0d", n, c, 250 * n); end
        checks++; if (step_idx !== exp_idx) begin errors++; $display("FAIL timer_idx: got %0d expected %0d", step_idx, exp_idx); end
        checks++; if (done !== (n == 8)) begin errors++; $display("FAIL timer_done: pulse %0d got %b expected %b", n, done, (n == 8)); end
        checks++; if (playing !== (n != 8)) begin errors++; $display("FAIL timer_playing: pulse %0d got %b expected %b", n, playing, (n != 8)); end
      end else if (done) begin
        checks++; errors++; $display("FAIL timer_stray_done: at cycle %0d got 1 expected 0", c);
      end
      if (n == 8) break;
    end
    checks++; if (n != 8) begin errors++; $display("FAIL timer_pulse_count: got %0d expected 8", n); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", done); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL idle_after_done: got %b expected 0", playing); end
  endtask

  task automatic test_tone();
    logic signed [31:0] prev;
    logic found;
    pattern = 16'h000F; loops = 7'd0; bpm = 10'd60;
    pulse_start();
    prev = sample; found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (sample !== prev && prev !== 32'sd0 && sample !== 32'sd0) begin found = 1'b1; break; end
      prev = sample;
    end
    checks++; if (!found) begin errors++; $display("FAIL tone_transition: got none expected one within 30 cycles"); end
    c0 = cyc; v0 = sample;
    checks++; if (v0 !== AP && v0 !== AN) begin errors++; $display("FAIL tone_level: got %h expected %h or %h", v0, AP, AN); end
    for (int k = 1; k < 30; k++) begin
      tick();
      checks++; if (sample !== exp_tone(cyc)) begin errors++; $display("FAIL tone_wave: cycle %0d got %h expected %h", cyc, sample, exp_tone(cyc)); end
    end
  endtask

  task automatic test_ready_low();
    logic signed [31:0] held;
    held = sample;
    sample_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++; if (sample !== held) begin errors++; $display("FAIL ready_hold: got %h expected %h", sample, held); end
      checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL ready_valid: got %b expected 1", sample_valid); end
      if (k >= 19 && ((cyc + 1 - c0) % 5) == 4) break;
    end
    sample_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (sample !== exp_tone(cyc)) begin errors++; $display("FAIL ready_resume: cycle %0d got %h expected %h", cyc, sample, exp_tone(cyc)); end
    end
  endtask

  task automatic test_saturate();
    logic signed [31:0] exp_v;
    pattern = 16'h00FF;
    tick(); tick();
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_v = (exp_tone(cyc) == AP) ? 32'sh6000_0000 : -32'sh6000_0000;
      checks++; if (sample !== exp_v) begin errors++; $display("FAIL mix_two: got %h expected %h", sample, exp_v); end
    end
    pattern = 16'hFFFF;
    tick(); tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_v = (exp_tone(cyc) == AP) ? SMAX : SMIN;
      checks++; if (sample !== exp_v) begin errors++; $display("FAIL mix_saturate: got %h expected %h", sample, exp_v); end
    end
  endtask

`ifdef ACCENT_EN
  task automatic test_accent();
    logic signed [31:0] exp_v;
    pattern = 16'h000F; accent = 16'h000F;
    tick(); tick();
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_v = (exp_tone(cyc) == AP) ? 32'sh6000_0000 : -32'sh6000_0000;
      checks++; if (sample !== exp_v) begin errors++; $display("FAIL accent_hit: got %h expected %h", sample, exp_v); end
    end
    accent = 16'h0000;
  endtask
`endif

  task automatic test_stop_start();
    pattern = 16'h000F;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL stop_wins: got %b expected 0", playing); end
    tick(); tick();
    checks++; if (sample !== 32'sd0) begin errors++; $display("FAIL stop_sample_zero: got %h expected 0", sample); end
    for (int k = 0; k < 10; k++) tick();
    checks++; if (sample !== 32'sd0) begin errors++; $display("FAIL idle_sample_zero: got %h expected 0", sample); end
    checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL idle_no_pulse: got %b expected 0", step_pulse); end
  endtask

  task automatic test_bpm_zero();
    int bad;
    bpm = 10'd0;
    pulse_start();
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL bpm0_playing: got %b expected 1", playing); end
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      tick();
      if (step_pulse !== 1'b0 || step_idx !== 2'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bpm0_frozen: got %0d bad cycles expected 0", bad); end
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL bpm0_still_playing: got %b expected 1", playing); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL bpm0_stop: got %b expected 0", playing); end
  endtask

  task automatic test_reset_mid();
    int n;
    int done_seen;
    bpm = 10'd60; loops = 7'd2; pattern = 16'h000F;
    pulse_start();
    n = 0; done_seen = 0;
    for (int c = 0; c < 1600 && n < 6; c++) begin
      tick();
      if (step_pulse) n++;
      if (done) done_seen++;
    end
    checks++; if (n != 6) begin errors++; $display("FAIL mid_pulses: got %0d expected 6", n); end
    checks++; if (step_idx !== 2'd2) begin errors++; $display("FAIL mid_idx: got %0d expected 2", step_idx); end
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) done_seen++;
    end
    rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (done) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL mid_no_done: got %0d done pulses expected 0", done_seen); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b expected 0", playing); end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b expected 1", sample_valid); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    bpm = 10'd60; loops = 7'd2; pattern = 16'h0000;
`ifdef ACCENT_EN
    accent = 16'h0000;
`endif
    half_period = {4{16'd5}};
    sample_ready = 1'b1;
    test_reset();
    test_step_timer();
    test_tone();
    test_ready_low();
    test_saturate();
`ifdef ACCENT_EN
    test_accent();
`endif
    test_stop_start();
    test_bpm_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
